regwb_arbiter: RTL and testbench



---
 rtl/regwb_arbiter_if.sv | 45 ++++
 rtl/regwb_arbiter.sv | 105 ++++++++++
 tb/tb_regwb_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/regwb_arbiter_if.sv
// Write-back arbiter bus: ALU result, load issue/return, decode source lookup and register-file write port.
interface regwb_arbiter_if;
  logic        alu_wr_valid;
  logic [4:0]  alu_wr_reg;
  logic [31:0] alu_wr_value;
  logic        alu_wr_ready;
  logic        load_issue;
  logic [4:0]  load_issue_reg;
  logic        load_issue_ready;
  logic        load_done_valid;
  logic [31:0] load_done_value;
  logic        load_done_ready;
  logic [4:0]  rd_sel1;
  logic [4:0]  rd_sel2;
  logic        hazard;
  logic        fwd_sel1;
  logic        fwd_sel2;
  logic [31:0] fwd_value;
  logic [4:0]  write_register;
  logic [31:0] write_value;

  modport slave (
    input  alu_wr_valid, alu_wr_reg, alu_wr_value,
    output alu_wr_ready,
    input  load_issue, load_issue_reg,
    output load_issue_ready,
    input  load_done_valid, load_done_value,
    output load_done_ready,
    input  rd_sel1, rd_sel2,
    output hazard, fwd_sel1, fwd_sel2, fwd_value,
    output write_register, write_value
  );

  modport master (
    output alu_wr_valid, alu_wr_reg, alu_wr_value,
    input  alu_wr_ready,
    output load_issue, load_issue_reg,
    input  load_issue_ready,
    output load_done_valid, load_done_value,
    input  load_done_ready,
    output rd_sel1, rd_sel2,
    input  hazard, fwd_sel1, fwd_sel2, fwd_value,
    input  write_register, write_value
  );
endinterface

// File: rtl/regwb_arbiter.sv
// Register-file write-port arbiter (load beats ALU) with single outstanding-load hazard scoreboard.
// Define REGWB_FWD_EN to forward the write-stage value to decode instead of stalling on it.
module regwb_arbiter (
  input  logic              clk,
  input  logic              rst_n,
  regwb_arbiter_if.slave    bus
);
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [REG_W-1:0]    pend_q, pend_d;
  // Stage register number doubles as the valid flag: x0 writes never load the stage.
  logic [REG_W-1:0]    wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0]   wb_value_q, wb_value_d;

  logic wb_valid;
  logic load_accept;
  logic alu_wr_ready_c, load_issue_ready_c, load_done_ready_c;
  logic hazard_c, fwd_sel1_c, fwd_sel2_c;
  logic match_wb1, match_wb2, match_pend1, match_pend2;

  assign wb_valid = (wb_reg_q != '0);

  // State, pending destination and write stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      wb_reg_q   <= '0;
      wb_value_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      wb_reg_q   <= wb_reg_d;
      wb_value_q <= wb_value_d;
    end
  end

  // Next state, arbitration and decode hazard.
  always_comb begin
    state_d            = state_q;
    pend_d             = pend_q;
    wb_reg_d           = '0;
    wb_value_d         = wb_value_q;
    load_issue_ready_c = (state_q == IDLE);
    load_done_ready_c  = (state_q == WAIT);
    load_accept        = load_done_ready_c && bus.load_done_valid;
    alu_wr_ready_c     = !load_accept &&
                         !((state_q == WAIT) && (bus.alu_wr_reg == pend_q));

    case (state_q)
      IDLE: begin
        if (bus.load_issue && (bus.load_issue_reg != '0)) begin
          state_d = WAIT;
          pend_d  = bus.load_issue_reg;
        end
      end
      WAIT: begin
        if (load_accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load_accept) begin
      wb_reg_d   = pend_q;
      wb_value_d = bus.load_done_value;
    end else if (bus.alu_wr_valid && alu_wr_ready_c && (bus.alu_wr_reg != '0)) begin
      wb_reg_d   = bus.alu_wr_reg;
      wb_value_d = bus.alu_wr_value;
    end

    match_pend1 = (bus.rd_sel1 != '0) && (state_q == WAIT) && (bus.rd_sel1 == pend_q);
    match_pend2 = (bus.rd_sel2 != '0) && (state_q == WAIT) && (bus.rd_sel2 == pend_q);
    match_wb1   = (bus.rd_sel1 != '0) && wb_valid && (bus.rd_sel1 == wb_reg_q);
    match_wb2   = (bus.rd_sel2 != '0) && wb_valid && (bus.rd_sel2 == wb_reg_q);

`ifdef REGWB_FWD_EN
    fwd_sel1_c = match_wb1;
    fwd_sel2_c = match_wb2;
    hazard_c   = match_pend1 || match_pend2;
`else
    fwd_sel1_c = 1'b0;
    fwd_sel2_c = 1'b0;
    hazard_c   = match_pend1 || match_pend2 || match_wb1 || match_wb2;
`endif
  end

  assign bus.alu_wr_ready     = alu_wr_ready_c;
  assign bus.load_issue_ready = load_issue_ready_c;
  assign bus.load_done_ready  = load_done_ready_c;
  assign bus.hazard           = hazard_c;
  assign bus.fwd_sel1         = fwd_sel1_c;
  assign bus.fwd_sel2         = fwd_sel2_c;
  assign bus.write_register   = wb_reg_q;
  assign bus.write_value      = wb_value_q;
`ifdef REGWB_FWD_EN
  assign bus.fwd_value        = wb_value_q;
`else
  assign bus.fwd_value        = '0;
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed self-checking bench for regwb_arbiter; expectations follow REGWB_FWD_EN when defined.
module tb_regwb_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  regwb_arbiter_if ifc ();

  regwb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    ifc.alu_wr_valid    = 1'b0;
    ifc.alu_wr_reg      = '0;
    ifc.alu_wr_value    = '0;
    ifc.load_issue      = 1'b0;
    ifc.load_issue_reg  = '0;
    ifc.load_done_valid = 1'b0;
    ifc.load_done_value = '0;
    ifc.rd_sel1         = '0;
    ifc.rd_sel2         = '0;
    #12;
    chk("rst_write_register", 32'(ifc.write_register), 32'd0);
    chk("rst_write_value", ifc.write_value, 32'd0);
    chk("rst_fwd_value", ifc.fwd_value, 32'd0);
    chk("rst_alu_ready", 32'(ifc.alu_wr_ready), 32'd1);
    chk("rst_issue_ready", 32'(ifc.load_issue_ready), 32'd1);
    chk("rst_done_ready", 32'(ifc.load_done_ready), 32'd0);
    chk("rst_hazard", 32'(ifc.hazard), 32'd0);
    chk("rst_fwd_sel", 32'({ifc.fwd_sel1, ifc.fwd_sel2}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU write x3, one-cycle visibility on the write port.
    ifc.alu_wr_valid = 1'b1; ifc.alu_wr_reg = 5'd3; ifc.alu_wr_value = 32'h12345678;
    #1 chk("alu_ready_idle", 32'(ifc.alu_wr_ready), 32'd1);
    tick();
    ifc.alu_wr_valid = 1'b0;
    ifc.rd_sel2 = 5'd3;
    #1;
    chk("alu_wr_reg3", 32'(ifc.write_register), 32'd3);
    chk("alu_wr_val3", ifc.write_value, 32'h12345678);
`ifdef REGWB_FWD_EN
    chk("fwd_hazard0", 32'(ifc.hazard), 32'd0);
    chk("fwd_sel2", 32'(ifc.fwd_sel2), 32'd1);
    chk("fwd_value", ifc.fwd_value, 32'h12345678);
`else
    chk("stage_hazard", 32'(ifc.hazard), 32'd1);
    chk("nofwd_sel2", 32'(ifc.fwd_sel2), 32'd0);
    chk("nofwd_value", ifc.fwd_value, 32'd0);
`endif
    tick();
    chk("alu_wr_cleared", 32'(ifc.write_register), 32'd0);
    chk("stage_hazard_gone", 32'(ifc.hazard), 32'd0);
    ifc.rd_sel2 = '0;

    // Load to x0: accepted, stays idle.
    ifc.load_issue = 1'b1; ifc.load_issue_reg = 5'd0;
    tick();
    ifc.load_issue = 1'b0;
    #1 chk("x0_load_idle", 32'(ifc.load_issue_ready), 32'd1);

    // Load x2, return 5 cycles later.
    ifc.load_issue = 1'b1; ifc.load_issue_reg = 5'd2;
    #1 chk("issue_ready", 32'(ifc.load_issue_ready), 32'd1);
    tick();
    ifc.load_issue = 1'b0;
    ifc.rd_sel1 = 5'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wait_hazard", 32'(ifc.hazard), 32'd1);
      chk("wait_issue_ready", 32'(ifc.load_issue_ready), 32'd0);
      tick();
    end
    ifc.rd_sel1 = 5'd0;
    #1 chk("wait_hazard_sel0", 32'(ifc.hazard), 32'd0);
    ifc.load_done_valid = 1'b1; ifc.load_done_value = 32'hDEADBEEF;
    #1 chk("done_ready", 32'(ifc.load_done_ready), 32'd1);
    tick();
    ifc.load_done_valid = 1'b0;
    #1;
    chk("load_wr_reg", 32'(ifc.write_register), 32'd2);
    chk("load_wr_val", ifc.write_value, 32'hDEADBEEF);
    chk("idle_after_done", 32'(ifc.load_issue_ready), 32'd1);
    chk("done_ready_idle", 32'(ifc.load_done_ready), 32'd0);
    tick();

    // Load return and ALU write in the same cycle.
    ifc.load_issue = 1'b1; ifc.load_issue_reg = 5'd2;
    tick();
    ifc.load_issue = 1'b0;
    ifc.load_done_valid = 1'b1; ifc.load_done_value = 32'hAA;
    ifc.alu_wr_valid = 1'b1; ifc.alu_wr_reg = 5'd4; ifc.alu_wr_value = 32'h55;
    #1 chk("collide_alu_ready", 32'(ifc.alu_wr_ready), 32'd0);
    tick();
    ifc.load_done_valid = 1'b0;
    #1;
    chk("collide_reg_load", 32'(ifc.write_register), 32'd2);
    chk("collide_val_load", ifc.write_value, 32'hAA);
    chk("collide_alu_retry", 32'(ifc.alu_wr_ready), 32'd1);
    tick();
    ifc.alu_wr_valid = 1'b0;
    #1;
    chk("collide_reg_alu", 32'(ifc.write_register), 32'd4);
    chk("collide_val_alu", ifc.write_value, 32'h55);
    tick();
    chk("collide_clear", 32'(ifc.write_register), 32'd0);

    // ALU write to the pending load destination.
    ifc.load_issue = 1'b1; ifc.load_issue_reg = 5'd2;
    tick();
    ifc.load_issue = 1'b0;
    ifc.alu_wr_valid = 1'b1; ifc.alu_wr_reg = 5'd2; ifc.alu_wr_value = 32'h77;
    #1 chk("waw_alu_blocked", 32'(ifc.alu_wr_ready), 32'd0);
    tick();
    chk("waw_no_write", 32'(ifc.write_register), 32'd0);
    ifc.load_done_valid = 1'b1; ifc.load_done_value = 32'h99;
    #1 chk("waw_blocked_done", 32'(ifc.alu_wr_ready), 32'd0);
    tick();
    ifc.load_done_valid = 1'b0;
    #1;
    chk("waw_first_reg", 32'(ifc.write_register), 32'd2);
    chk("waw_first_val", ifc.write_value, 32'h99);
    chk("waw_alu_ready", 32'(ifc.alu_wr_ready), 32'd1);
    tick();
    ifc.alu_wr_valid = 1'b0;
    chk("waw_second_reg", 32'(ifc.write_register), 32'd2);
    chk("waw_second_val", ifc.write_value, 32'h77);

    // Issue and done in the same WAIT cycle: issue refused, retried next cycle.
    ifc.load_issue = 1'b1; ifc.load_issue_reg = 5'd5;
    tick();
    ifc.load_issue_reg = 5'd6;
    ifc.load_done_valid = 1'b1; ifc.load_done_value = 32'h1234;
    #1 chk("issue_refused", 32'(ifc.load_issue_ready), 32'd0);
    tick();
    ifc.load_done_valid = 1'b0;
    #1;
    chk("issue_done_reg", 32'(ifc.write_register), 32'd5);
    chk("issue_retry_ready", 32'(ifc.load_issue_ready), 32'd1);
    tick();
    ifc.load_issue = 1'b0;
    ifc.rd_sel2 = 5'd6;
    #1;
    chk("retry_wait", 32'(ifc.load_issue_ready), 32'd0);
    chk("retry_hazard", 32'(ifc.hazard), 32'd1);
    ifc.rd_sel2 = 5'd0;
    ifc.load_done_valid = 1'b1; ifc.load_done_value = 32'hCAFE;
    tick();
    ifc.load_done_valid = 1'b0;

    // Reset during WAIT with a stage write pending.
    ifc.load_issue = 1'b1; ifc.load_issue_reg = 5'd7;
    ifc.alu_wr_valid = 1'b1; ifc.alu_wr_reg = 5'd8; ifc.alu_wr_value = 32'hBEEF;
    tick();
    ifc.load_issue = 1'b0; ifc.alu_wr_valid = 1'b0;
    chk("pre_rst_reg", 32'(ifc.write_register), 32'd8);
    chk("pre_rst_wait", 32'(ifc.load_issue_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_flush_reg", 32'(ifc.write_register), 32'd0);
    chk("rst_flush_val", ifc.write_value, 32'd0);
    chk("rst_idle", 32'(ifc.load_issue_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(ifc.load_issue_ready), 32'd1);
    chk("post_rst_done_ready", 32'(ifc.load_done_ready), 32'd0);
    chk("post_rst_no_write", 32'(ifc.write_register), 32'd0);

    // ALU write to x0 never reaches the write port.
    ifc.alu_wr_valid = 1'b1; ifc.alu_wr_reg = 5'd0; ifc.alu_wr_value = 32'hFFFF;
    #1 chk("x0_alu_ready", 32'(ifc.alu_wr_ready), 32'd1);
    tick();
    ifc.alu_wr_valid = 1'b0;
    chk("x0_no_write", 32'(ifc.write_register), 32'd0);
    chk("x0_no_hazard", 32'(ifc.hazard), 32'd0);

    // Back-to-back ALU writes, no bubble.
    ifc.alu_wr_valid = 1'b1; ifc.alu_wr_reg = 5'd9; ifc.alu_wr_value = 32'h9;
    tick();
    chk("b2b_first", 32'(ifc.write_register), 32'd9);
    ifc.alu_wr_reg = 5'd10; ifc.alu_wr_value = 32'hA;
    tick();
    ifc.alu_wr_valid = 1'b0;
    chk("b2b_second_reg", 32'(ifc.write_register), 32'd10);
    chk("b2b_second_val", ifc.write_value, 32'hA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
